regfile_operand_fetch: RTL and testbench
========================================

Name: regfile_operand_fetch

Overview:
- 32-entry general-purpose register file with a registered operand-fetch stage; sits directly upstream of the ALU.
- Two read ports produce the ALU a/b operands with 1-cycle latency.
- One write port accepts write-back results.
- Same-cycle write-to-read bypass; register 0 hardwired to zero; stall holds the operands steady while the ALU is busy.

Parameters:
- DATA_W, 32, register and operand width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- rd_en  in  1  fetch request; captures rs_addr/rt_addr this cycle.
- stall  in  1  hold a, b, op_valid; blocks a new fetch.
- rs_addr  in  ADDR_W  source register for operand a.
- rt_addr  in  ADDR_W  source register for operand b.
- we  in  1  write enable from write-back.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  write-back data.
- a  out  DATA_W  registered operand a to the ALU.
- b  out  DATA_W  registered operand b to the ALU.
- op_valid  out  1  a/b hold a fetched operand pair.

Behaviour:
- Interface decided: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - All 32 registers become 0.
  - a=0, b=0, op_valid=0.
  - Reset wins over we, rd_en and stall in the same cycle.
  - Reset mid-fetch discards the fetch.
- Write:
  - On a rising edge with rst_n=1, we=1 and wr_addr!=0: mem[wr_addr] <= wr_data.
  - Writes to address 0 are dropped; mem[0] reads 0 forever.
  - Writes proceed regardless of stall.
- Fetch (rd_en=1, stall=0) at edge N updates a, b and op_valid at edge N, so they are visible in cycle N+1 (1-cycle latency).
  - a <= 0 if rs_addr==0.
  - Otherwise a <= wr_data if we && wr_addr==rs_addr (bypass: new value, never stale).
  - Otherwise a <= mem[rs_addr].
  - b follows identical rules using rt_addr.
  - op_valid <= 1.
- Idle (rd_en=0, stall=0): op_valid <= 0. a and b keep their last values; they are don't-care for the consumer.
- Stall=1: a, b and op_valid hold. rd_en is ignored and the request is not queued; upstream must re-present it.
- rs_addr==rt_addr: both ports return the same value, bypass included.
- Bypass with wr_addr==0 never fires; a 0 result still comes from the r0 rule.
- No X on outputs after reset; all addresses are in range by construction (full 2**ADDR_W depth).

Decomposition:
- Shared package:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO = 0 constant.
  - Register index type (ADDR_W bits), shared with the decoder and write-back stage.
- Natural sub-module: regfile_read_port. It is purely combinational: address, mem array, we/wr_addr/wr_data in; selected value with zero and bypass rules out. It is instantiated twice (a and b).
- The storage array and output registers stay in the top module.

Test Plan:
- Reset: preload r5=0x1234 then assert rst_n=0 for one edge → a=b=0, op_valid=0; a fetch of r5 returns 0.
- Write then read:
  - Write r1=50 and r2=40 in separate cycles.
  - rd_en with rs=1, rt=2 → next cycle a=50, b=40, op_valid=1.
- Same-cycle bypass:
  - r3 holds 7.
  - we=1, wr_addr=3, wr_data=100 with rd_en, rs=3, rt=3 in the same cycle → a=b=100.
  - A later fetch of r3 also gives 100.
- r0 protection: we=1, wr_addr=0, wr_data=0xFFFFFFFF with a fetch of rs=0 → a=0; a later fetch of r0 → 0.
- Stall:
  - Fetch r1/r2 (a=50, b=40).
  - Next cycle stall=1 with rd_en, rs=3 → a=50, b=40, op_valid=1 held.
  - Write r1=9 during the stall → stored; a fetch of r1 after the stall returns 9.
- Idle/valid: rd_en=0 for one cycle after a fetch → op_valid drops to 0 the next cycle; back-to-back fetches keep op_valid=1 continuously.

Source files
------------

// File: rtl/regfile_operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_operand_fetch_pkg
//  Description : Shared widths, constants and types for the register file /
//                operand-fetch slice (decoder, fetch stage, write-back).
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_operand_fetch_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Architectural zero register index.
    localparam int REG_ZERO   = 0;

    // Register index as seen by the decoder and write-back stage.
    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage : regfile_operand_fetch_pkg
`default_nettype wire

// File: rtl/regfile_operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_operand_fetch_if
//  Description : Fetch request, write-back and operand bundle between the
//                decode/write-back side (master) and the register file (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_operand_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic              stall;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              op_valid;

    modport master (
        output rd_en, stall, rs_addr, rt_addr, we, wr_addr, wr_data,
        input  a, b, op_valid
    );

    modport slave (
        input  rd_en, stall, rs_addr, rt_addr, we, wr_addr, wr_data,
        output a, b, op_valid
    );
endinterface : regfile_operand_fetch_if
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : Combinational register read port. Returns zero for r0,
//                forwards a same-cycle write-back to the same index, else
//                reads the storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_operand_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_mem [2**ADDR_W],
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    output logic      [DATA_W-1:0] o_data
);

    // r0 rule has priority; a write to r0 can therefore never be forwarded.
    always_comb begin
        o_data = i_mem[i_addr];
        if (i_addr == ADDR_W'(REG_ZERO)) begin
            o_data = '0;
        end else if (i_we && (i_wr_addr == i_addr)) begin
            o_data = i_wr_data;
        end
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_operand_fetch
//  Description : 32-entry register file with a registered two-operand fetch
//                stage feeding the ALU. 1-cycle read latency, write-to-read
//                bypass, hardwired r0, stall holds the operand pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    regfile_operand_fetch_if.slave   bus
);

    localparam int c_DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_op_valid;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    // Storage: cleared on reset; write-back ignores stall, r0 never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.we && (bus.wr_addr != ADDR_W'(REG_ZERO))) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .i_addr    (bus.rs_addr),
        .i_mem     (r_mem),
        .i_we      (bus.we),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_data    (w_a)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .i_addr    (bus.rt_addr),
        .i_mem     (r_mem),
        .i_we      (bus.we),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_data    (w_b)
    );

    // Operand registers: stall freezes everything, idle only drops valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.rd_en) begin
                r_a        <= w_a;
                r_b        <= w_b;
                r_op_valid <= 1'b1;
            end else begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign bus.a        = r_a;
    assign bus.b        = r_b;
    assign bus.op_valid = r_op_valid;

endmodule : regfile_operand_fetch
`default_nettype wire

// File: tb/tb_regfile_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_operand_fetch
//  Description : Directed self-checking bench for regfile_operand_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_operand_fetch;
    import regfile_operand_fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    regfile_operand_fetch_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs, clock it, then settle past the edge.
    task automatic step(input logic rst_v, input logic rd, input logic stl,
                        input reg_idx_t rs, input reg_idx_t rt,
                        input logic wen, input reg_idx_t wa, input logic [31:0] wd);
        rst_n       = rst_v;
        bus.rd_en   = rd;
        bus.stall   = stl;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        bus.we      = wen;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ops(input string tag, input logic [31:0] ea,
                             input logic [31:0] eb, input logic ev);
        check({tag, ".a"}, bus.a, ea);
        check({tag, ".b"}, bus.b, eb);
        check({tag, ".v"}, {31'd0, bus.op_valid}, {31'd0, ev});
    endtask

    initial begin
        //     rst  rd stl rs  rt  we  wa  wd
        step(1'b0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        check_ops("reset0", 32'h0, 32'h0, 1'b0);

        // Preload r5, fetch it, then reset: operands and storage cleared.
        step(1'b1, 0, 0, 5'd0, 5'd0, 1, 5'd5, 32'h1234);
        step(1'b1, 1, 0, 5'd5, 5'd5, 0, 5'd0, 32'h0);
        check_ops("pre_rst", 32'h1234, 32'h1234, 1'b1);
        step(1'b0, 1, 1, 5'd5, 5'd5, 1, 5'd6, 32'hDEAD);
        check_ops("rst_wins", 32'h0, 32'h0, 1'b0);
        step(1'b1, 1, 0, 5'd5, 5'd6, 0, 5'd0, 32'h0);
        check_ops("post_rst", 32'h0, 32'h0, 1'b1);

        // Write then read.
        step(1'b1, 0, 0, 5'd0, 5'd0, 1, 5'd1, 32'd50);
        step(1'b1, 0, 0, 5'd0, 5'd0, 1, 5'd2, 32'd40);
        step(1'b1, 1, 0, 5'd1, 5'd2, 0, 5'd0, 32'h0);
        check_ops("wr_rd", 32'd50, 32'd40, 1'b1);

        // Same-cycle bypass on both ports, then stored value.
        step(1'b1, 0, 0, 5'd0, 5'd0, 1, 5'd3, 32'd7);
        step(1'b1, 1, 0, 5'd3, 5'd3, 1, 5'd3, 32'd100);
        check_ops("bypass", 32'd100, 32'd100, 1'b1);
        step(1'b1, 1, 0, 5'd3, 5'd0, 0, 5'd0, 32'h0);
        check_ops("after_byp", 32'd100, 32'd0, 1'b1);

        // Bypass on the b port only.
        step(1'b1, 1, 0, 5'd2, 5'd4, 1, 5'd4, 32'h55);
        check_ops("byp_b", 32'd40, 32'h55, 1'b1);

        // r0 protection: write to r0 is neither bypassed nor stored.
        step(1'b1, 1, 0, 5'd0, 5'd3, 1, 5'd0, 32'hFFFF_FFFF);
        check_ops("r0_byp", 32'h0, 32'd100, 1'b1);
        step(1'b1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        check_ops("r0_read", 32'h0, 32'h0, 1'b1);

        // Stall holds operands while a write still lands.
        step(1'b1, 1, 0, 5'd1, 5'd2, 0, 5'd0, 32'h0);
        check_ops("pre_stall", 32'd50, 32'd40, 1'b1);
        step(1'b1, 1, 1, 5'd3, 5'd3, 1, 5'd1, 32'd9);
        check_ops("stall", 32'd50, 32'd40, 1'b1);
        step(1'b1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0);
        check("idle.v", {31'd0, bus.op_valid}, 32'd0);
        step(1'b1, 1, 0, 5'd1, 5'd2, 0, 5'd0, 32'h0);
        check_ops("post_stall", 32'd9, 32'd40, 1'b1);

        // Back-to-back fetches keep valid high; idle drops it.
        step(1'b1, 1, 0, 5'd3, 5'd1, 0, 5'd0, 32'h0);
        check_ops("b2b", 32'd100, 32'd9, 1'b1);
        step(1'b1, 1, 0, 5'd4, 5'd5, 0, 5'd0, 32'h0);
        check_ops("b2b2", 32'h55, 32'h0, 1'b1);
        step(1'b1, 0, 0, 5'd1, 5'd1, 0, 5'd0, 32'h0);
        check("idle2.v", {31'd0, bus.op_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_operand_fetch
`default_nettype wire
